// File: rtl/verlet_node_array.sv
`default_nettype none
// ============================================================================
// verlet_node_array : time-multiplexed Verlet integrator, one node per cycle
// Rev 1.0
// ============================================================================
module verlet_node_array #(
  parameter int                 NODES      = 8,
  parameter int                 W          = 32,
  parameter int                 FRAC       = 12,
  parameter int                 BASE_X     = 200,
  parameter int                 DIST       = 10,
  parameter logic [W-1:0]       GRAVITY    = W'(32'h000004CD),
  parameter int                 DAMP_SHIFT = 0,
  parameter logic [NODES-1:0]   PIN_MASK   = 'b1,
  localparam int                IDW        = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step_start,
  output logic           step_busy,
  output logic           step_done,
  input  logic           fix_valid,
  output logic           fix_ready,
  input  logic [IDW-1:0] fix_id,
  input  logic [W-1:0]   fix_x,
  input  logic [W-1:0]   fix_y,
  input  logic [IDW-1:0] rd_id,
  output logic [W-1:0]   rd_x,
  output logic [W-1:0]   rd_y
);

  localparam logic [W-1:0] c_base_x = W'(BASE_X) << FRAC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] idx_q, idx_d;

  logic [W-1:0] x_q  [NODES];
  logic [W-1:0] y_q  [NODES];
  logic [W-1:0] px_q [NODES];
  logic [W-1:0] py_q [NODES];

  logic [W-1:0] rd_x_q, rd_y_q, rd_x_d, rd_y_d;

  logic [W-1:0]        cur_x, cur_y, cur_px, cur_py;
  logic [W-1:0]        vx_raw, vy_raw, vx_eff, vy_eff;
  logic [W-1:0]        nx, ny;
  logic                commit, fix_fire;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d = S_STEP;
          idx_d   = '0;
        end
      end
      S_STEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDW'(NODES - 1)) begin
          state_d = S_DONE;
          idx_d   = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign step_busy = (state_q != S_IDLE);
  assign step_done = (state_q == S_DONE);
  assign fix_ready = (state_q == S_IDLE);
  assign commit    = (state_q == S_STEP);
  assign fix_fire  = fix_valid && fix_ready;

  // ---------------------------------------------------------------- datapath
  always_comb begin
    cur_x  = '0;
    cur_y  = '0;
    cur_px = '0;
    cur_py = '0;
    for (int i = 0; i < NODES; i++) begin
      if (idx_q == IDW'(i)) begin
        cur_x  = x_q[i];
        cur_y  = y_q[i];
        cur_px = px_q[i];
        cur_py = py_q[i];
      end
    end
  end

  assign vx_raw = cur_x - cur_px;
  assign vy_raw = cur_y - cur_py;

  generate
    if (DAMP_SHIFT > 0) begin : g_damp
      // Shift into signed nets first so >>> stays arithmetic.
      logic signed [W-1:0] vx_sh, vy_sh;
      assign vx_sh  = $signed(vx_raw) >>> DAMP_SHIFT;
      assign vy_sh  = $signed(vy_raw) >>> DAMP_SHIFT;
      assign vx_eff = vx_raw - $unsigned(vx_sh);
      assign vy_eff = vy_raw - $unsigned(vy_sh);
    end else begin : g_nodamp
      assign vx_eff = vx_raw;
      assign vy_eff = vy_raw;
    end
  endgenerate

  assign nx = cur_x + vx_eff;
  assign ny = cur_y + vy_eff - GRAVITY;

  always_comb begin
    rd_x_d = '0;
    rd_y_d = '0;
    for (int i = 0; i < NODES; i++) begin
      if (rd_id == IDW'(i)) begin
        rd_x_d = x_q[i];
        rd_y_d = y_q[i];
      end
    end
  end

  // ---------------------------------------------------------------- storage
  // Writes only happen in IDLE and commits only in STEP, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_x_q <= '0;
      rd_y_q <= '0;
      for (int i = 0; i < NODES; i++) begin
        x_q[i]  <= c_base_x;
        px_q[i] <= c_base_x;
        y_q[i]  <= W'(DIST * (i + 1)) << FRAC;
        py_q[i] <= W'(DIST * (i + 1)) << FRAC;
      end
    end else begin
      rd_x_q <= rd_x_d;
      rd_y_q <= rd_y_d;
      for (int i = 0; i < NODES; i++) begin
        if (commit && (idx_q == IDW'(i)) && !PIN_MASK[i]) begin
          px_q[i] <= x_q[i];
          py_q[i] <= y_q[i];
          x_q[i]  <= nx;
          y_q[i]  <= ny;
        end else if (fix_fire && (fix_id == IDW'(i))) begin
          x_q[i]  <= fix_x;
          y_q[i]  <= fix_y;
        end
      end
    end
  end

  assign rd_x = rd_x_q;
  assign rd_y = rd_y_q;

endmodule
`default_nettype wire
